// File: rtl/full_adder.sv
// Registered ripple-carry full adder, WIDTH bits wide, with its half-sum,
// generate and propagated-carry terms also registered onto the ports.
module full_adder #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  logic [WIDTH-1:0] f_c;
  logic [WIDTH-1:0] m_c;
  logic [WIDTH-1:0] n_c;
  logic [WIDTH-1:0] s_c;
  logic             cout_c;
  logic             carry;

  // Ripple chain built from the f/m/n terms so the exposed terms stay exact.
  // A running scalar carry avoids a self-referencing carry vector.
  always_comb begin
    f_c   = a ^ b;
    m_c   = a & b;
    n_c   = '0;
    s_c   = '0;
    carry = c;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      n_c[i] = f_c[i] & carry;
      s_c[i] = f_c[i] ^ carry;
      carry  = m_c[i] | n_c[i];
    end
    cout_c = carry;
  end

  // Output registers with synchronous, active-high clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      f    <= '0;
      m    <= '0;
      n    <= '0;
      s    <= '0;
      cout <= 1'b0;
    end else begin
      f    <= f_c;
      m    <= m_c;
      n    <= n_c;
      s    <= s_c;
      cout <= cout_c;
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder at widths 1, 4 and 8: arithmetic reference model checked
// every cycle, plus directed vectors with hand-computed expectations.
module tb_full_adder;

  logic       clk;
  logic       rst;
  logic [0:0] a1, b1, f1, m1, n1, s1;
  logic       c1, cout1;
  logic [3:0] a4, b4, f4, m4, n4, s4;
  logic       c4, cout4;
  logic [7:0] a8, b8, f8, m8, n8, s8;
  logic       c8, cout8;

  int errors = 0;
  int checks = 0;

  logic        valid = 1'b0;
  logic [32:0] exp1, exp4, exp8;

  // {cout,s}, f, m, n for abc = 000..111, bit/entry i <-> abc = i
  logic [1:0] tt_cs [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
  logic [7:0] f_tab = 8'h3C;
  logic [7:0] m_tab = 8'hC0;
  logic [7:0] n_tab = 8'h28;
  logic [2:0] lat_in  [3] = '{3'b000, 3'b111, 3'b010};
  logic [1:0] lat_exp [3] = '{2'b00, 2'b11, 2'b01};

  full_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .c(c1),
    .f(f1), .m(m1), .n(n1), .s(s1), .cout(cout1)
  );
  full_adder #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .c(c4),
    .f(f4), .m(m4), .n(n4), .s(s4), .cout(cout4)
  );
  full_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .c(c8),
    .f(f8), .m(m8), .n(n8), .s(s8), .cout(cout8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [32:0] pack(input logic co, input logic [7:0] s,
                                       input logic [7:0] f, input logic [7:0] m,
                                       input logic [7:0] n);
    return {co, s, f, m, n};
  endfunction

  // Reference: arithmetic sum; carry into bit i recovered as sum^a^b.
  function automatic logic [32:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic c, input int w);
    logic [8:0] sum;
    logic [7:0] mask, am, bm, cin, f;
    mask = 8'((9'(1) << w) - 9'(1));
    am   = a & mask;
    bm   = b & mask;
    sum  = 9'(am) + 9'(bm) + 9'(c);
    cin  = sum[7:0] ^ am ^ bm;
    f    = am ^ bm;
    return {sum[w], sum[7:0] & mask, f, am & bm, f & cin};
  endfunction

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs captured from the inputs sampled at each edge.
  always @(posedge clk) begin
    if (rst) begin
      exp1  = '0;
      exp4  = '0;
      exp8  = '0;
      valid = 1'b1;
    end else begin
      exp1 = model(8'(a1), 8'(b1), c1, 1);
      exp4 = model(8'(a4), 8'(b4), c4, 4);
      exp8 = model(a8, b8, c8, 8);
    end
  end

  // Per-cycle comparison against the model once the first reset edge has passed.
  always @(negedge clk) begin
    if (valid) begin
      chk("model_w1", pack(cout1, 8'(s1), 8'(f1), 8'(m1), 8'(n1)), exp1);
      chk("model_w4", pack(cout4, 8'(s4), 8'(f4), 8'(m4), 8'(n4)), exp4);
      chk("model_w8", pack(cout8, s8, f8, m8, n8), exp8);
      chk("mn_excl_w4", 33'(m4 & n4), 33'd0);
      chk("mn_excl_w8", 33'(m8 & n8), 33'd0);
    end
  end

  initial begin
    rst = 1'b1;
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    a4 = '0; b4 = '0; c4 = 1'b0;
    a8 = '0; b8 = '0; c8 = 1'b0;

    // Reset held for two edges with all-ones inputs
    repeat (2) @(posedge clk);
    #1;
    chk("rst_w1", pack(cout1, 8'(s1), 8'(f1), 8'(m1), 8'(n1)), 33'd0);
    chk("rst_w4", pack(cout4, 8'(s4), 8'(f4), 8'(m4), 8'(n4)), 33'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_w1", pack(cout1, 8'(s1), 8'(f1), 8'(m1), 8'(n1)),
        pack(1'b1, 8'd1, 8'd0, 8'd1, 8'd0));

    // Exhaustive truth table, each vector held two cycles
    for (int i = 0; i < 8; i++) begin
      @(negedge clk) {a1, b1, c1} = 3'(i);
      repeat (2) @(posedge clk);
      #1;
      chk("tt_cout_s", 33'({cout1, s1}), 33'(tt_cs[i]));
      chk("tt_f", 33'(f1), 33'(f_tab[i]));
      chk("tt_m", 33'(m1), 33'(m_tab[i]));
      chk("tt_n", 33'(n1), 33'(n_tab[i]));
    end

    // One-cycle latency with inputs changing every cycle
    for (int i = 0; i < 3; i++) begin
      @(negedge clk) {a1, b1, c1} = lat_in[i];
      @(posedge clk); #1;
      chk("latency", 33'({cout1, s1}), 33'(lat_exp[i]));
    end

    // Full ripple through four bits
    @(negedge clk) begin a4 = 4'hF; b4 = 4'h1; c4 = 1'b0; end
    @(posedge clk); #1;
    chk("ripple_f_1", pack(cout4, 8'(s4), 8'(f4), 8'(m4), 8'(n4)),
        pack(1'b1, 8'h0, 8'hE, 8'h1, 8'hE));
    @(negedge clk) begin a4 = 4'hF; b4 = 4'h0; c4 = 1'b1; end
    @(posedge clk); #1;
    chk("ripple_f_cin", pack(cout4, 8'(s4), 8'(f4), 8'(m4), 8'(n4)),
        pack(1'b1, 8'h0, 8'hF, 8'h0, 8'hF));

    // Random stream with a one-cycle reset in the middle
    for (int i = 0; i < 20; i++) begin
      @(negedge clk) begin
        a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom);
        rst = (i == 10);
      end
      if (i == 10) begin
        @(posedge clk); #1;
        chk("mid_rst_w4", pack(cout4, 8'(s4), 8'(f4), 8'(m4), 8'(n4)), 33'd0);
      end
    end
    @(negedge clk) rst = 1'b0;

    // Random regression on all widths
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk) begin
        a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
        a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom);
        a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      end
    end

    repeat (2) @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
